// File: rtl/fb_scan_arbiter.sv
// Framebuffer port arbiter: display scan-out reads take priority, the draw client
// gets a write slot at least every BURST reads, and returned pixels feed the pixel FIFO.
module fb_scan_arbiter #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 19,
  parameter int FRAME_PIX = 307200,
  parameter int RD_LAT    = 2,
  parameter int BURST     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync,
  input  logic              fifo_afull,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              frame_err
);

  localparam int RUN_W = $clog2(BURST + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(FRAME_PIX - 1);
  localparam logic [RUN_W-1:0]  BURST_MAX = RUN_W'(BURST);

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    RUN       = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [RUN_W-1:0]    rd_run_reg, rd_run_next;
  logic                frame_err_reg, frame_err_next;
  logic                vs_d_reg;
  logic [RD_LAT-1:0]   vld_reg, vld_next;

  logic vs_edge;
  logic read_ok;
  logic grant_wr;
  logic grant_rd;

  assign vs_edge = vs_d_reg & ~vsync;
  assign read_ok = (state_reg == RUN) & ~fifo_afull & ~vs_edge;

  // Grants are masked during reset so the RAM port is quiet while rst is high.
  assign grant_wr = ~rst & wr_req & (~read_ok | (rd_run_reg == BURST_MAX));
  assign grant_rd = ~rst & ~grant_wr & read_ok;

  always_comb begin
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    wr_ack    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_wr) begin
      mem_we    = 1'b1;
      wr_ack    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (grant_rd) begin
      mem_re    = 1'b1;
      mem_addr  = rd_ptr_reg;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rd_ptr_next    = rd_ptr_reg;
    frame_err_next = frame_err_reg;
    case (state_reg)
      SYNC_WAIT, DONE: begin
        if (vs_edge) begin
          state_next  = RUN;
          rd_ptr_next = '0;
        end
      end
      RUN: begin
        if (vs_edge) begin
          frame_err_next = 1'b1;
          rd_ptr_next    = '0;
        end else if (grant_rd) begin
          // The pointer parks on the last pixel rather than wrapping.
          if (rd_ptr_reg == LAST_PIX) begin
            state_next = DONE;
          end else begin
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
          end
        end
      end
      default: state_next = SYNC_WAIT;
    endcase
  end

  always_comb begin
    rd_run_next = rd_run_reg;
    if (!wr_req || grant_wr) begin
      rd_run_next = '0;
    end else if (grant_rd) begin
      rd_run_next = rd_run_reg + RUN_W'(1);
    end
  end

  // Read-valid pipe: bit RD_LAT-1 lines up with mem_rdata for the matching read.
  for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_vld
    if (gi == 0) begin : g_head
      assign vld_next[gi] = grant_rd;
    end else begin : g_tail
      assign vld_next[gi] = vld_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SYNC_WAIT;
      rd_ptr_reg    <= '0;
      rd_run_reg    <= '0;
      frame_err_reg <= 1'b0;
      vs_d_reg      <= 1'b1;
      vld_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      rd_ptr_reg    <= rd_ptr_next;
      rd_run_reg    <= rd_run_next;
      frame_err_reg <= frame_err_next;
      vs_d_reg      <= vsync;
      vld_reg       <= vld_next;
    end
  end

  assign fifo_wr_en = vld_reg[RD_LAT-1];
  assign fifo_din   = fifo_wr_en ? mem_rdata : '0;
  assign frame_err  = frame_err_reg;

endmodule

// File: doc/fb_scan_arbiter.md
Name: fb_scan_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between two clients: display scan-out and a draw/write client.
- Display scan-out fills the 24-bit pixel FIFO that feeds the VGA/DVI timing generator.
- Display reads have priority so the FIFO does not starve. A burst limit guarantees forward progress for writes.
- The read pointer is re-aligned to pixel 0 on each vsync pulse.

Parameters:
- DATA_W, 24, pixel width (FIFO and RAM data).
- ADDR_W, 19, RAM address width.
- FRAME_PIX, 307200, pixels fetched per frame (640x480).
- RD_LAT, 2, RAM read latency in cycles (>=1).
- BURST, 8, max consecutive read grants while wr_req is pending.

Ports:
- clk  in  1  pixel-domain clock
- rst  in  1  synchronous reset, active high
- vsync  in  1  from timing generator, active-low pulse
- fifo_afull  in  1  pixel FIFO almost full; FIFO asserts it with at least RD_LAT+1 free entries remaining
- fifo_wr_en  out  1  push to pixel FIFO
- fifo_din  out  DATA_W  pixel to FIFO
- mem_addr  out  ADDR_W  RAM address
- mem_re  out  1  RAM read strobe
- mem_we  out  1  RAM write strobe
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after mem_re
- wr_req  in  1  write client request; wr_addr and wr_data held stable until wr_ack
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse, in the same cycle as mem_we
- frame_err  out  1  sticky: vsync edge arrived before the frame was fully fetched

Behaviour:
- One clock, synchronous active-high reset on rst.
- Reset values: all outputs 0, state SYNC_WAIT, rd_ptr=0, rd_run=0, read-valid pipe cleared.
- vs_edge: vsync registered as vs_d. vs_edge = vs_d & ~vsync (falling edge). vs_d resets to 1.
- FSM states:
  - SYNC_WAIT: no reads. On vs_edge go to RUN with rd_ptr=0.
  - RUN: fetch. When the read of pixel FRAME_PIX-1 is issued, go to DONE.
  - DONE: no reads. On vs_edge go to RUN with rd_ptr=0.
  - In RUN, on vs_edge: set frame_err=1, rd_ptr=0, stay in RUN.
- read_ok = (state==RUN) & ~fifo_afull & ~vs_edge.
- Grant, one access per cycle, evaluated every cycle:
  - If wr_req & (~read_ok | rd_run==BURST): write. Outputs mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1. Set rd_run=0.
  - Else if read_ok: read. Outputs mem_re=1, mem_addr=rd_ptr. Increment rd_ptr. If wr_req, rd_run=rd_run+1.
  - Else: idle.
  - rd_run is forced to 0 whenever wr_req=0.
- mem_re and mem_we are never high in the same cycle. mem_addr, mem_we, mem_re and wr_ack are combinational from the grant logic; wr_ack is not registered.
- Read return:
  - RD_LAT-deep valid shift register. A read in cycle N produces fifo_wr_en=1 and fifo_din=mem_rdata in cycle N+RD_LAT.
  - In-flight reads always complete, including across vs_edge and state changes. Only rst flushes them.
  - fifo_din is 0 when fifo_wr_en=0.
- rd_ptr is ADDR_W bits, never exceeds FRAME_PIX-1, and never wraps to 0 except on vs_edge.
- Simultaneous vs_edge and wr_req: the write is granted, because read_ok=0.
- fifo_afull rising while reads are in flight: the in-flight reads still push. The FIFO headroom requirement above guarantees no overflow.
- rst mid-frame: everything returns to SYNC_WAIT and pending returns are discarded. Fetch restarts only after the next vs_edge.
- frame_err is cleared only by rst.

Test Plan (FRAME_PIX=16, RD_LAT=2, BURST=4 unless stated):
- Reset then idle, vsync held high 20 cycles -> no mem_re, no fifo_wr_en, state SYNC_WAIT, all outputs 0.
- vsync low 1 cycle, fifo_afull=0, wr_req=0 -> mem_re asserted 16 consecutive cycles with addr 0..15. fifo_wr_en for 16 cycles, lagging by 2 cycles, fifo_din matching RAM model contents. Then DONE with no further reads.
- Fetch active, wr_req held high with wr_addr=5, wr_data=0xABCDEF -> pattern of 4 reads, 1 write (wr_ack=1, mem_we=1, addr 5), then reads resume at the next rd_ptr. The RAM model shows 0xABCDEF at address 5.
- fifo_afull=1 after 6 reads, wr_req=1 -> reads stop, the write is granted immediately. The 2 in-flight pushes still occur. Reads resume at addr 6 when fifo_afull=0.
- Second vsync pulse after only 10 pixels fetched -> frame_err=1, next mem_re addr=0, frame_err stays 1 through the following complete frame.
- rst asserted 1 cycle after mem_re -> no fifo_wr_en follows, state SYNC_WAIT, rd_ptr=0, frame_err=0.
